// File: rtl/pipe_ctrl_if.sv
// Request/stall bundle between the pipeline stages (master) and the stall
// controller (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              stallreq_id_i;
  logic              mc_start_i;
  logic [CNT_W-1:0]  mc_cycles_i;
  logic              mc_annul_i;
  logic [5:0]        stall_o;
  logic              mc_busy_o;
  logic              mc_done_o;
  logic [CNT_W-1:0]  mc_cnt_o;
  logic [PERF_W-1:0] stall_cnt_o;

  modport master (
    output stallreq_id_i, mc_start_i, mc_cycles_i, mc_annul_i,
    input  stall_o, mc_busy_o, mc_done_o, mc_cnt_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_id_i, mc_start_i, mc_cycles_i, mc_annul_i,
    output stall_o, mc_busy_o, mc_done_o, mc_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges the decode load-use stall with a
// down-counter sequencer for multi-cycle execute ops, plus a stalled-cycle counter.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_TWO  = CNT_ONE << 1;
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic              w_long_op;
  logic              w_ex_stall;
  logic [5:0]        w_stall;

  // Ops needing fewer than two cycles complete inside the normal EX slot.
  assign w_long_op = (bus.mc_cycles_i >= CNT_TWO);

  // Stall vector: EX hold dominates the decode hazard; everything quiet in reset.
  always_comb begin
    w_ex_stall = 1'b0;
    w_stall    = 6'b000000;
    if (rst) begin
      w_ex_stall = 1'b0;
      w_stall    = 6'b000000;
    end else begin
      if (bus.mc_annul_i) begin
        w_ex_stall = 1'b0;
      end else if (r_state == S_BUSY) begin
        w_ex_stall = 1'b1;
      end else if ((r_state == S_IDLE) && bus.mc_start_i && w_long_op) begin
        w_ex_stall = 1'b1;
      end else begin
        w_ex_stall = 1'b0;
      end

      if (w_ex_stall) begin
        w_stall = 6'b001111;
      end else if (bus.stallreq_id_i) begin
        w_stall = 6'b000111;
      end else begin
        w_stall = 6'b000000;
      end
    end
  end

  assign bus.stall_o     = w_stall;
  assign bus.mc_busy_o   = ~rst & (r_state == S_BUSY);
  assign bus.mc_done_o   = ~rst & ~bus.mc_annul_i & (r_state == S_DONE);
  assign bus.mc_cnt_o    = rst ? CNT_ZERO : r_cnt;
  assign bus.stall_cnt_o = rst ? {PERF_W{1'b0}} : r_stall_cnt;

  // Multi-cycle sequencer; the start cycle itself counts as the first stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else if (bus.mc_annul_i) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.mc_start_i && w_long_op) begin
            r_state <= S_BUSY;
            r_cnt   <= bus.mc_cycles_i - CNT_ONE;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        S_BUSY: begin
          // Leave at one (or below) so the counter can never wrap.
          if (r_cnt <= CNT_ONE) begin
            r_state <= S_DONE;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_state <= S_BUSY;
            r_cnt   <= r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Saturating count of cycles in which any pipeline register is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= {PERF_W{1'b0}};
    end else if ((w_stall != 6'b000000) && (r_stall_cnt != PERF_MAX)) begin
      r_stall_cnt <= r_stall_cnt + PERF_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized check of pipe_ctrl against a cycle-age reference model;
// a second instance with a 4-bit perf counter exercises saturation.
module tb_pipe_ctrl;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W), .PERF_W(32)) bus ();
  pipe_ctrl    #(.CNT_W(CNT_W), .PERF_W(32)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  pipe_ctrl_if #(.CNT_W(CNT_W), .PERF_W(4))  bus4 ();
  pipe_ctrl    #(.CNT_W(CNT_W), .PERF_W(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an op is described by its age in cycles since the start cycle.
  bit          m_active = 1'b0;
  int          m_age    = 0;
  int          m_n      = 0;
  logic [31:0] m_perf   = 32'd0;

  int tcur       = 0;
  int obs_stalls = 0;
  int obs_done_t = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setin(input logic r, input logic id, input logic st,
                       input int n, input logic an);
    rst                  = r;
    bus.stallreq_id_i    = id;
    bus.mc_start_i       = st;
    bus.mc_cycles_i      = CNT_W'(n);
    bus.mc_annul_i       = an;
  endtask

  task automatic cycle();
    logic [5:0] e_stall;
    logic       e_ex, e_busy, e_done;
    int         e_cnt;
    int         n_in;
    @(negedge clk);
    n_in   = int'(bus.mc_cycles_i);
    e_ex   = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_cnt  = 0;
    if (!rst) begin
      if (m_active) begin
        if (m_age < m_n) begin
          e_ex   = !bus.mc_annul_i;
          e_busy = 1'b1;
          e_cnt  = m_n - m_age;
        end else begin
          e_done = !bus.mc_annul_i;
        end
      end else if (bus.mc_start_i && n_in >= 2) begin
        e_ex = !bus.mc_annul_i;
      end
    end
    e_stall = rst ? 6'h00 : (e_ex ? 6'h0F : (bus.stallreq_id_i ? 6'h07 : 6'h00));
    chk("stall_o",     64'(bus.stall_o),     64'(e_stall));
    chk("mc_busy_o",   64'(bus.mc_busy_o),   64'(e_busy));
    chk("mc_done_o",   64'(bus.mc_done_o),   64'(e_done));
    chk("mc_cnt_o",    64'(bus.mc_cnt_o),    64'(e_cnt));
    chk("stall_cnt_o", 64'(bus.stall_cnt_o), rst ? 64'd0 : 64'(m_perf));
    if (bus.stall_o == 6'h0F) obs_stalls++;
    if (bus.mc_done_o) obs_done_t = tcur;
    @(posedge clk);
    tcur++;
    if (rst) begin
      m_active = 1'b0;
      m_perf   = 32'd0;
    end else begin
      if (e_stall != 6'h00 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      if (bus.mc_annul_i) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_age++;
        if (m_age > m_n) m_active = 1'b0;
      end else if (bus.mc_start_i && n_in >= 2) begin
        m_active = 1'b1;
        m_age    = 1;
        m_n      = n_in;
      end
    end
    #1;
  endtask

  initial begin
    int t0;
    int n_r;
    logic st_r;
    rst4 = 1'b1;
    bus4.stallreq_id_i = 1'b0;
    bus4.mc_start_i    = 1'b0;
    bus4.mc_cycles_i   = 6'd0;
    bus4.mc_annul_i    = 1'b0;

    // Reset with active-looking inputs: everything must stay quiet.
    setin(1'b1, 1'b1, 1'b1, 5, 1'b0);
    repeat (3) cycle();

    // Idle, then a three-cycle op.
    setin(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) cycle();
    setin(1'b0, 1'b0, 1'b1, 3, 1'b0);
    repeat (4) cycle();
    setin(1'b0, 1'b0, 1'b0, 3, 1'b0);
    cycle();

    // Decode hazard alone, then overlapping a busy op.
    setin(1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) cycle();
    setin(1'b0, 1'b1, 1'b1, 4, 1'b0);
    repeat (5) cycle();
    setin(1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle();

    // Annul two cycles into a four-cycle op.
    setin(1'b0, 1'b0, 1'b1, 4, 1'b0);
    repeat (2) cycle();
    setin(1'b0, 1'b1, 1'b1, 4, 1'b1);
    cycle();
    setin(1'b0, 1'b0, 1'b0, 4, 1'b0);
    repeat (6) cycle();

    // Single-cycle ops and the shortest real multi-cycle op.
    setin(1'b0, 1'b0, 1'b1, 1, 1'b0);
    repeat (2) cycle();
    setin(1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (2) cycle();
    setin(1'b0, 1'b0, 1'b1, 2, 1'b0);
    repeat (3) cycle();
    setin(1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle();

    // Largest legal op.
    obs_stalls = 0;
    obs_done_t = -1;
    t0 = tcur;
    setin(1'b0, 1'b0, 1'b1, 63, 1'b0);
    repeat (64) cycle();
    setin(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) cycle();
    chk("n63_stall_cycles", 64'(obs_stalls), 64'd63);
    chk("n63_done_time",    64'(obs_done_t - t0), 64'd63);

    // Reset in the middle of an op aborts it silently.
    setin(1'b0, 1'b0, 1'b1, 5, 1'b0);
    repeat (2) cycle();
    setin(1'b1, 1'b0, 1'b1, 5, 1'b0);
    cycle();
    setin(1'b0, 1'b0, 1'b0, 5, 1'b0);
    repeat (6) cycle();

    // Randomized traffic following the hold-start-until-done protocol.
    n_r  = 3;
    st_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_active && m_age < m_n) begin
        st_r = 1'b1;
      end else begin
        st_r = ($urandom_range(0, 1) == 1);
        n_r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 63))
                                           : int'($urandom_range(0, 6));
      end
      setin(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), st_r, n_r,
            ($urandom_range(0, 15) == 0));
      cycle();
    end
    setin(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) cycle();

    // Narrow perf counter must hold at all-ones.
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    bus4.stallreq_id_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk("perf4_sat", 64'(bus4.stall_cnt_o), (k < 15) ? 64'(k) : 64'd15);
    end
    chk("perf4_stall_o", 64'(bus4.stall_o), 64'h07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
